// File: rtl/tinker_pkg.sv
// Shared Tinker datapath definitions: muldiv opcodes, muldiv FSM states and the
// default integer register width.
package tinker_pkg;

    localparam int TINKER_XLEN = 64;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_MULH = 2'b01,
        MD_DIV  = 2'b10,
        MD_REM  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } muldiv_state_e;

endpackage

// File: rtl/tinker_muldiv_signfix.sv
// Conditional two's-complement negation for a parametric width. Used both to
// take operand magnitudes on entry and to reapply the result sign on exit.
module tinker_muldiv_signfix #(
    parameter int W = 64
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    always_comb begin
        res = neg ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;
    end

endmodule

// File: rtl/tinker_muldiv_unit.sv
// Iterative multiply/divide unit (shift-add multiply, restoring divide) with
// valid/ready on both sides. Build option TINKER_MULDIV_EARLY_OUT_EN enables
// early completion of multiplies once the remaining multiplier bits are zero.
module tinker_muldiv_unit
    import tinker_pkg::*;
#(
    parameter int WIDTH = TINKER_XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_dbz,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    muldiv_state_e          state_q, state_d;
    muldiv_op_e             op_q, op_d;
    logic                   res_neg_q, res_neg_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       out_result_q, out_result_d;
    logic                   out_dbz_q, out_dbz_d;

    muldiv_op_e             req_op;
    logic                   req_div;
    logic                   a_neg, b_neg;
    logic [WIDTH-1:0]       mag_a, mag_b;
    logic                   op_div;
    logic                   early_out;
    logic [WIDTH:0]         div_trial;
    logic [WIDTH-1:0]       div_rem_next;
    logic [2*WIDTH-1:0]     acc_step;
    logic [2*WIDTH-1:0]     exit_val, exit_res;
    logic [WIDTH-1:0]       final_result;

    assign req_op  = muldiv_op_e'(in_op);
    assign req_div = in_op[1];
    assign a_neg   = in_signed & in_a[WIDTH-1];
    assign b_neg   = in_signed & in_b[WIDTH-1];
    assign op_div  = (op_q == MD_DIV) || (op_q == MD_REM);

    tinker_muldiv_signfix #(.W(WIDTH)) u_mag_a (
        .val (in_a),
        .neg (a_neg),
        .res (mag_a)
    );

    tinker_muldiv_signfix #(.W(WIDTH)) u_mag_b (
        .val (in_b),
        .neg (b_neg),
        .res (mag_b)
    );

`ifdef TINKER_MULDIV_EARLY_OUT_EN
    assign early_out = !op_div && (mplier_q[WIDTH-1:1] == '0);
`else
    assign early_out = 1'b0;
`endif

    // One iteration: acc holds {remainder, quotient/dividend} for divide and the
    // running product for multiply, where the multiplicand is pre-shifted.
    always_comb begin
        div_trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mcand_q[WIDTH-1:0]};
        div_rem_next = div_trial[WIDTH] ? acc_q[2*WIDTH-2:WIDTH-1] : div_trial[WIDTH-1:0];
        if (op_div) begin
            acc_step = {div_rem_next, acc_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
            acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        end
    end

    always_comb begin
        exit_val = acc_step;
        if (op_div) begin
            exit_val = {{WIDTH{1'b0}},
                        (op_q == MD_DIV) ? acc_step[WIDTH-1:0] : acc_step[2*WIDTH-1:WIDTH]};
        end
    end

    tinker_muldiv_signfix #(.W(2 * WIDTH)) u_fix_res (
        .val (exit_val),
        .neg (res_neg_q),
        .res (exit_res)
    );

    assign final_result = (op_q == MD_MULH) ? exit_res[2*WIDTH-1:WIDTH] : exit_res[WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        res_neg_d    = res_neg_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        out_result_d = out_result_q;
        out_dbz_d    = out_dbz_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d      = req_op;
                    out_dbz_d = 1'b0;
                    cnt_d     = '0;
                    // Zero divisor never iterates; the quotient of 0 mirrors the old ALU.
                    if (req_div && (in_b == '0)) begin
                        state_d      = DONE;
                        out_dbz_d    = 1'b1;
                        out_result_d = (req_op == MD_DIV) ? '0 : in_a;
                    end else begin
                        state_d   = RUN;
                        res_neg_d = (req_op == MD_REM) ? a_neg : (a_neg ^ b_neg);
                        if (req_div) begin
                            acc_d    = {{WIDTH{1'b0}}, mag_a};
                            mcand_d  = {{WIDTH{1'b0}}, mag_b};
                            mplier_d = '0;
                        end else begin
                            acc_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, mag_a};
                            mplier_d = mag_b;
                        end
                    end
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (!op_div) begin
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                if ((cnt_q == CNT_W'(WIDTH - 1)) || early_out) begin
                    state_d      = DONE;
                    out_result_d = final_result;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= MD_MUL;
            res_neg_q    <= 1'b0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
            out_result_q <= '0;
            out_dbz_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            res_neg_q    <= res_neg_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            cnt_q        <= cnt_d;
            out_result_q <= out_result_d;
            out_dbz_q    <= out_dbz_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = out_result_q;
    assign out_dbz    = out_dbz_q;

endmodule

// File: tb/tb_tinker_muldiv_unit.sv
// Self-checking bench for tinker_muldiv_unit: directed cases plus randomized
// requests checked against a plain-arithmetic reference model.
module tb_tinker_muldiv_unit;

    localparam int W = 64;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic         in_signed;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_dbz;
    logic         busy;

    int tests_run    = 0;
    int tests_failed = 0;

    tinker_muldiv_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_signed  (in_signed),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dbz    (out_dbz),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: sign-extended operands multiplied mod 2^(2W); native signed divide.
    function automatic void refModel(input logic [1:0] op, input logic sgn,
                                     input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] res, output logic dbz);
        logic [2*W-1:0] ea, eb, prod;
        longint sa, sb;
        dbz = 1'b0;
        res = '0;
        if (!op[1]) begin
            ea   = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
            eb   = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
            prod = ea * eb;
            res  = (op == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        end else if (b == '0) begin
            dbz = 1'b1;
            res = (op == 2'b10) ? '0 : a;
        end else if (!sgn) begin
            res = (op == 2'b10) ? (a / b) : (a % b);
        end else if (a == MIN_VAL && b == '1) begin
            res = (op == 2'b10) ? MIN_VAL : '0;
        end else begin
            sa  = a;
            sb  = b;
            res = (op == 2'b10) ? (sa / sb) : (sa % sb);
        end
    endfunction

    // Edges counted from (and including) the accepting edge until out_valid shows.
    function automatic int expLatency(input logic [1:0] op, input logic sgn, input logic [W-1:0] b);
        if (op[1] && b == '0) return 1;
`ifdef TINKER_MULDIV_EARLY_OUT_EN
        if (!op[1]) begin
            logic [W-1:0] mag;
            int msb;
            mag = (sgn && b[W-1]) ? -b : b;
            msb = 0;
            for (int i = 0; i < W; i++) if (mag[i]) msb = i;
            return 2 + msb;
        end
`endif
        return W + 1;
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic sgn,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("in_ready_before_req", {63'd0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        in_op     = op;
        in_signed = sgn;
        in_a      = a;
        in_b      = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_op     = 2'($urandom);
        in_signed = 1'($urandom);
        in_a      = {$urandom, $urandom};
        in_b      = {$urandom, $urandom};
    endtask

    task automatic waitDone(output int edges, output int busy_cycles);
        edges       = 1;
        busy_cycles = 0;
        forever begin
            if (busy) busy_cycles++;
            if (out_valid || edges >= 200) break;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [1:0] op, input logic sgn,
                               input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] exp_res;
        logic         exp_dbz;
        int           lat, edges, busy_cycles;
        refModel(op, sgn, a, b, exp_res, exp_dbz);
        lat = expLatency(op, sgn, b);
        applyStimulus(op, sgn, a, b);
        waitDone(edges, busy_cycles);
        checkOutput({tag, "_result"}, out_result, exp_res);
        if (op[1]) checkOutput({tag, "_dbz"}, {63'd0, out_dbz}, {63'd0, exp_dbz});
        checkOutput({tag, "_latency"}, 64'(edges), 64'(lat));
        checkOutput({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(lat));
        @(posedge clk);
        #1;
        checkOutput({tag, "_idle_after"}, {61'd0, in_ready, out_valid, busy}, 64'b100);
    endtask

    initial begin
        int edges, busy_cycles;
        logic [1:0]   r_op;
        logic         r_sgn;
        logic [W-1:0] r_a, r_b;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_signed = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_flags", {60'd0, in_ready, out_valid, out_dbz, busy}, 64'b1000);
        checkOutput("reset_result", out_result, '0);
        @(negedge clk);
        reset = 1'b0;

        runAndCheck("mul_7x6", 2'b00, 1'b0, 64'd7, 64'd6);
        runAndCheck("sdiv_m7_2", 2'b10, 1'b1, -64'sd7, 64'd2);
        runAndCheck("srem_m7_2", 2'b11, 1'b1, -64'sd7, 64'd2);
        runAndCheck("div_100_0", 2'b10, 1'b0, 64'd100, 64'd0);
        runAndCheck("rem_100_0", 2'b11, 1'b0, 64'd100, 64'd0);
        runAndCheck("srem_neg_0", 2'b11, 1'b1, -64'sd5, 64'd0);
        runAndCheck("mulh_max_x2", 2'b01, 1'b0, '1, 64'd2);
        runAndCheck("sdiv_min_m1", 2'b10, 1'b1, MIN_VAL, '1);
        runAndCheck("srem_min_m1", 2'b11, 1'b1, MIN_VAL, '1);
        runAndCheck("smulh_m1_m1", 2'b01, 1'b1, '1, '1);
        runAndCheck("mul_by_1", 2'b00, 1'b0, 64'h1234_5678_9abc_def0, 64'd1);

        // Backpressure: result must sit still while the consumer stalls.
        out_ready = 1'b0;
        applyStimulus(2'b10, 1'b0, 64'd100, 64'd7);
        waitDone(edges, busy_cycles);
        checkOutput("bp_valid", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op    = 2'b00;
            in_a     = 64'd3;
            in_b     = 64'd5;
            @(posedge clk);
            #1;
            checkOutput("bp_hold_result", out_result, 64'd14);
            checkOutput("bp_hold_flags", {61'd0, in_ready, out_valid, out_dbz}, 64'b010);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release", {61'd0, in_ready, out_valid, busy}, 64'b100);

        // Reset in the middle of a multiply.
        applyStimulus(2'b00, 1'b0, 64'd123, 64'd456);
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_reset", {61'd0, in_ready, out_valid, busy}, 64'b100);
        @(negedge clk);
        reset = 1'b0;

        // Flush in the middle of a divide.
        applyStimulus(2'b10, 1'b1, -64'sd1000, 64'd3);
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_flush", {61'd0, in_ready, out_valid, busy}, 64'b100);
        @(negedge clk);
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no_stale_result", {63'd0, out_valid}, 64'd0);

        runAndCheck("after_flush", 2'b11, 1'b1, -64'sd1000, 64'd7);

        for (int n = 0; n < 24; n++) begin
            r_op  = 2'($urandom);
            r_sgn = 1'($urandom);
            r_a   = {$urandom, $urandom};
            r_b   = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: ;
                1: begin r_a = 64'($urandom_range(0, 255)); r_b = 64'($urandom_range(0, 255)); end
                2: r_b = '0;
                3: r_b = 64'($urandom_range(1, 15));
                default: begin r_a = MIN_VAL; r_b = '1; end
            endcase
            runAndCheck("rand", r_op, r_sgn, r_a, r_b);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tinker_muldiv_unit.md
Name: tinker_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the Tinker integer datapath. It replaces the single-cycle `*` and `/` paths of the combined ALU/FPU with a multi-cycle engine. Adds signed mode, remainder, high-half multiply, divide-by-zero flagging and a valid/ready handshake on both sides. Sits beside the ALU; the core stalls issue while `in_ready` is low.

Parameters:
WIDTH, 64, operand and result width in bits; must be at least 8.
CNT_W, $clog2(WIDTH+1), iteration counter width (localparam, derived; not overridable).

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  synchronous, active-high.
flush  input  1  synchronous abort of any operation in flight.
in_valid  input  1  request valid.
in_ready  output  1  unit can accept a request.
in_op  input  2  00 MUL (low half), 01 MULH (high half), 10 DIV (quotient), 11 REM.
in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
in_a  input  WIDTH  multiplicand / dividend.
in_b  input  WIDTH  multiplier / divisor.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_result  output  WIDTH  result.
out_dbz  output  1  divide by zero; meaningful only with out_valid and op DIV/REM.
busy  output  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset: state IDLE, in_ready=1, out_valid=0, out_result=0, out_dbz=0, busy=0.
- Reset has priority over flush; flush has priority over every other event.
- flush: state goes to IDLE on the next edge and out_valid drops. An aborted result is never presented.
- Accept occurs at an edge where in_valid && in_ready. in_ready = (state==IDLE). No acceptance in RUN or DONE.
- On accept:
  - op, signed flag and operand magnitudes are latched. When in_signed, |x| is taken; MIN maps to itself as an unsigned value.
  - Result sign is latched: MUL/MULH = sign(a)^sign(b); DIV = sign(a)^sign(b); REM = sign(a).
- MUL/MULH:
  - Radix-2 shift-add over WIDTH iterations into a 2*WIDTH product register.
  - RUN lasts exactly WIDTH cycles. On the final iteration the product is conditionally negated (2*WIDTH-bit two's complement).
  - MUL returns the low WIDTH bits; MULH returns the high WIDTH bits.
- DIV/REM:
  - Restoring division over WIDTH iterations. Quotient and remainder are conditionally negated per the latched signs.
  - Signed MIN / -1 gives quotient MIN (wraps) and remainder 0; no flag is raised.
- Divide by zero (in_b==0, op DIV/REM) bypasses RUN: IDLE goes directly to DONE.
  - Quotient = 0 (matches the legacy ALU behaviour), remainder = in_a unmodified, out_dbz=1.
- Latency:
  - Accept at edge E gives out_valid=1 after edge E+WIDTH+1.
  - Divide by zero: out_valid=1 after edge E+1.
- DONE: out_valid=1. out_result and out_dbz are held stable until out_valid && out_ready, then the FSM returns to IDLE on that edge. out_valid is never deasserted without a handshake except on reset or flush.
- in_a, in_b and in_op may change freely after accept; the unit uses only latched copies.
- out_dbz is cleared on every accept.

Optional Feature:
Macro TINKER_MULDIV_EARLY_OUT_EN.
- Defined: in RUN for MUL/MULH, when the remaining unshifted multiplier bits are all zero, the remaining product shift is applied in one step and the FSM enters DONE on the next edge. Latency is then between 2 and WIDTH+1 cycles; results are identical. For a multiplier of 0 or 1, out_valid is set after edge E+2.
- Undefined: fixed latency as specified above. DIV/REM latency is fixed in both builds.

Decomposition:
- Shared package tinker_pkg holds:
  - muldiv_op_e enum (MD_MUL, MD_MULH, MD_DIV, MD_REM).
  - muldiv_state_e enum (IDLE, RUN, DONE).
  - localparam TINKER_XLEN=64, used as the WIDTH default at instantiation.
- One sub-module: tinker_muldiv_signfix. It is combinational: magnitude and conditional negation for a parametric width, instantiated for operand entry and for result exit.

Test Plan:
- Unsigned MUL 7*6, out_ready=1 → out_result=42, out_valid after exactly 65 edges, busy high for 65 cycles.
- Signed DIV -7/2 then REM -7/2 → 0xFFFF_FFFF_FFFF_FFFD (-3), then 0xFFFF_FFFF_FFFF_FFFF (-1), out_dbz=0.
- DIV 100/0 and REM 100/0 → result 0 and 100 respectively, out_dbz=1, out_valid after 1 edge.
- Unsigned MULH 0xFFFF_FFFF_FFFF_FFFF*2 → 1; signed DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000, REM → 0.
- Backpressure: out_ready low for 10 cycles in DONE → out_result and out_dbz stable, in_ready=0, new in_valid ignored; out_ready high → IDLE next edge.
- Reset asserted 20 cycles into a MUL, then flush 20 cycles into a DIV → out_valid=0, in_ready=1, busy=0 after the edge; the next request completes correctly.
